// File: rtl/struct_in_packed_rx.sv
// struct_in_packed_rx
//   Receiving end of a packed {data} struct port. Words arrive on a valid/ready
//   input, are buffered in a DEPTH-entry RAM and leave through a registered
//   output stage. Producer protocol violations are flagged on a sticky error.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_a_valid  producer word valid
//   i_a_data   producer payload (struct field "data")
//   o_a_ready  receiver can accept a word this cycle (registered)
//   o_b_valid  output word valid (registered)
//   o_b_data   output payload (registered)
//   i_b_ready  consumer accepts the output word
//   o_count    words held, including the output register
//   o_err      sticky producer protocol violation

module struct_in_packed_rx #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_valid,
  input  logic [W-1:0]  i_a_data,
  output logic          o_a_ready,
  output logic          o_b_valid,
  output logic [W-1:0]  o_b_data,
  input  logic          i_b_ready,
  output logic [CW-1:0] o_count,
  output logic          o_err
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] OneCnt   = CW'(1);

  // State
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          err_q, err_d;

  // Previous-cycle view of the producer, used by the protocol checker
  logic          prev_valid_q;
  logic          prev_ready_q;
  logic [W-1:0]  prev_data_q;

  // Datapath helpers
  logic          push;
  logic          pop;
  logic          load_slot;
  logic          bypass;
  logic          mem_we;
  logic [CW-1:0] ram_cnt;
  logic          ram_empty;
  logic          stall;
  logic          retract;
  logic          data_chg;

  assign push = i_a_valid & ready_q;
  assign pop  = out_valid_q & i_b_ready;

  // The output register is part of o_count; the RAM holds the remainder.
  assign ram_cnt   = count_q - (out_valid_q ? OneCnt : '0);
  assign ram_empty = (ram_cnt == '0);

  // The output register takes a new word whenever it is empty or being drained.
  assign load_slot = ~out_valid_q | pop;
  assign bypass    = load_slot & ram_empty & push;
  assign mem_we    = push & ~bypass;

  // Output register refill and pointer advance
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    if (load_slot) begin
      if (!ram_empty) begin
        // Oldest buffered word goes first; any concurrent push lands in the RAM.
        out_valid_d = 1'b1;
        out_data_d  = mem_q[rd_ptr_q];
        rd_ptr_d    = rd_ptr_q + PW'(1);
      end else if (push) begin
        out_valid_d = 1'b1;
        out_data_d  = i_a_data;
      end else begin
        // Data is left as-is; only valid drops.
        out_valid_d = 1'b0;
      end
    end

    if (mem_we) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
  end

  // Occupancy and registered ready
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + OneCnt;
      2'b01:   count_d = count_q - OneCnt;
      default: count_d = count_q;
    endcase
    // Computed from next-state count so a pop at full reopens ready one cycle later,
    // without any combinational path from i_b_ready to o_a_ready.
    ready_d = (count_d < DepthCnt);
  end

  // Protocol checker: a word offered but not taken must be held unchanged.
  always_comb begin
    stall    = prev_valid_q & ~prev_ready_q;
    retract  = stall & ~i_a_valid;
    data_chg = stall & i_a_valid & (i_a_data != prev_data_q);
    err_d    = err_q | retract | data_chg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q      <= '0;
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_ready_q <= 1'b0;
      prev_data_q  <= '0;
    end else begin
      count_q      <= count_d;
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
      prev_valid_q <= i_a_valid;
      prev_ready_q <= ready_q;
      prev_data_q  <= i_a_data;
    end
  end

  // Storage RAM; contents need no reset since pointers and count gate every read.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= i_a_data;
    end
  end

  assign o_a_ready = ready_q;
  assign o_b_valid = out_valid_q;
  assign o_b_data  = out_data_q;
  assign o_count   = count_q;
  assign o_err     = err_q;

`ifndef SYNTHESIS
  a_count_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count_q <= DepthCnt);
  a_valid_tracks_count : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    out_valid_q == (count_q != '0));
`endif

endmodule

// File: tb/tb_struct_in_packed_rx.sv
module tb_struct_in_packed_rx;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0;
  logic [W-1:0]  a_data = '0;
  logic          a_ready;
  logic          b_valid;
  logic [W-1:0]  b_data;
  logic          b_ready = 1'b0;
  logic [CW-1:0] count;
  logic          err;

  struct_in_packed_rx #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_a_valid (a_valid),
    .i_a_data  (a_data),
    .o_a_ready (a_ready),
    .o_b_valid (b_valid),
    .o_b_data  (b_data),
    .i_b_ready (b_ready),
    .o_count   (count),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pop_total = 0;
  int max_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of words the receiver is holding.
  logic [W-1:0] exp_q[$];
  bit           exp_ready = 1'b0;
  bit           exp_err = 1'b0;
  bit           prev_valid = 1'b0;
  bit           prev_ready = 1'b0;
  logic [W-1:0] prev_data = '0;

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_count", int'(count), 0);
      check("rst_a_ready", int'(a_ready), 0);
      check("rst_b_valid", int'(b_valid), 0);
      check("rst_b_data", int'(b_data), 0);
      check("rst_err", int'(err), 0);
      exp_q.delete();
      exp_ready  = 1'b0;
      exp_err    = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = '0;
    end else begin
      check("count", int'(count), exp_q.size());
      check("a_ready", int'(a_ready), int'(exp_ready));
      check("b_valid", int'(b_valid), int'(exp_q.size() != 0));
      if (b_valid && exp_q.size() > 0) check("b_data", int'(b_data), int'(exp_q[0]));
      check("err", int'(err), int'(exp_err));
      // A word offered and refused must be offered again unchanged.
      if (prev_valid && !prev_ready && (!a_valid || a_data != prev_data)) exp_err = 1'b1;
      prev_valid = a_valid;
      prev_ready = exp_ready;
      prev_data  = a_data;
      if (b_valid && b_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pop_total++;
      end
      if (a_valid && a_ready) exp_q.push_back(a_data);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      exp_ready = (exp_q.size() < DEPTH);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one word until accepted; returns at posedge+1 with valid still high.
  task automatic send(input logic [W-1:0] d, input bit rnd_b);
    bit done = 1'b0;
    a_valid = 1'b1;
    a_data  = d;
    for (int i = 0; i < 500 && !done; i++) begin
      if (rnd_b) b_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (a_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %0d not accepted, expected acceptance", d);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    a_valid = 1'b0;
    b_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      tick(1);
      if (count == '0) done = 1'b1;
    end
    n_cmp++;
    if (!done || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: count %0d model %0d, expected 0", count, exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int base;
    int c0;

    // 1: reset, single word, one-cycle latency
    b_ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    send(8'hA5, 1'b0);
    a_valid = 1'b0;
    check("p1_b_valid", int'(b_valid), 1);
    check("p1_b_data", int'(b_data), 8'hA5);
    check("p1_count", int'(count), 1);
    tick(1);
    check("p1_count_after_pop", int'(count), 0);
    check("p1_b_valid_after_pop", int'(b_valid), 0);

    // 2: fill while stalled, fifth word held, then ordered release
    b_ready = 1'b0;
    base = pop_total;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    a_data = 8'h05;
    check("p2_count_full", int'(count), 4);
    check("p2_ready_full", int'(a_ready), 0);
    tick(3);
    check("p2_count_held", int'(count), 4);
    b_ready = 1'b1;
    send(8'h05, 1'b0);
    drain();
    check("p2_pops", pop_total - base, 5);

    // 3: streaming, one word per cycle
    b_ready = 1'b1;
    max_cnt = 0;
    base = pop_total;
    c0 = cyc;
    for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
    check("p3_cycles", cyc - c0, 256);
    drain();
    check("p3_pops", pop_total - base, 256);
    check("p3_max_count_le1", int'(max_cnt <= 1), 1);

    // 4: full, lone pop reopens ready, then push+pop keeps count
    b_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
    a_data = 8'h77;
    tick(2);
    check("p4_count_full", int'(count), 4);
    b_ready = 1'b1;
    tick(1);
    b_ready = 1'b0;
    check("p4_count_after_pop", int'(count), 3);
    check("p4_ready_reopen", int'(a_ready), 1);
    b_ready = 1'b1;
    tick(1);
    a_valid = 1'b0;
    b_ready = 1'b0;
    check("p4_count_push_pop", int'(count), 3);
    drain();

    // 5: data change during stall, then retraction during stall
    b_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i + 16), 1'b0);
    a_data = 8'h3C;
    tick(1);
    check("p5_err_before", int'(err), 0);
    a_data = 8'h3D;
    tick(1);
    check("p5_err_data_change", int'(err), 1);
    a_valid = 1'b0;
    tick(5);
    check("p5_err_sticky", int'(err), 1);
    do_reset();
    check("p5_err_cleared", int'(err), 0);
    for (int i = 0; i < 4; i++) send(8'(i + 32), 1'b0);
    a_data = 8'h55;
    tick(1);
    a_valid = 1'b0;
    tick(1);
    check("p5_err_retract", int'(err), 1);
    drain();
    check("p5_err_still_set", int'(err), 1);
    do_reset();

    // Random traffic with random back-pressure and idle gaps
    base = pop_total;
    for (int i = 0; i < 600; i++) begin
      send(8'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        a_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          b_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    end
    drain();
    check("rnd_pops", pop_total - base, 600);
    check("rnd_err", int'(err), 0);

    // 6: async reset with three words buffered
    b_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(i + 200), 1'b0);
    a_valid = 1'b0;
    check("p6_count_3", int'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("p6_async_count", int'(count), 0);
    check("p6_async_b_valid", int'(b_valid), 0);
    check("p6_async_b_data", int'(b_data), 0);
    check("p6_async_a_ready", int'(a_ready), 0);
    check("p6_async_err", int'(err), 0);
    base = pop_total;
    tick(2);
    rst_n = 1'b1;
    b_ready = 1'b1;
    tick(5);
    check("p6_no_stale_pops", pop_total - base, 0);
    check("p6_count_after", int'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
